powlib_bus_fifo: RTL and testbench
==================================

# powlib_bus_fifo

Single-clock, first-word-fall-through FIFO that carries an address word and a data word side by side with a valid/ready handshake on both ends. It is the standard decoupling buffer on powlib bus paths, for example at the input and output of RAM and AXI bridge IP. It also provides a programmable nearly-full flag, so upstream pipelines with in-flight beats can stall early without loss.

## Interface
- ID, "BUSFIFO": string identifier, used only in debug messages.
- EDBG, 0: when 1, simulation-only `$display` on every push, pop and dropped write.
- D, 8: depth in entries; power of two, ≥ 2.
- NFS, 0: nearly-full slack, 0..D-1; `wrnf` asserts when occupancy ≥ D-NFS.
- B_AW, 32: address width.
- B_DW, 32: data width.

Ports:
- clk, in, 1: the single clock.
- rst, in, 1: reset, asynchronous and active-high.
- wraddr, in, B_AW: write-side address.
- wrdata, in, B_DW: write-side data.
- wrvld, in, 1: write valid.
- wrrdy, out, 1: write ready, meaning not full.
- wrnf, out, 1: nearly full.
- rdaddr, out, B_AW: head-entry address.
- rddata, out, B_DW: head-entry data.
- rdvld, out, 1: read valid, meaning not empty.
- rdrdy, in, 1: read ready.

## Operation
- Storage is D entries of {addr, data}, B_AW+B_DW bits wide.
- Push occurs when wrvld && wrrdy. The entry is written at the write pointer, and the write pointer advances modulo D.
- Pop occurs when rdvld && rdrdy. The read pointer advances modulo D.
- rdaddr/rddata always present the entry at the read pointer (fall-through). They are don't-care while rdvld=0.
- An occupancy counter `cnt` spans 0..D and is clog2(D+1) bits wide:
  - increments on push-only;
  - decrements on pop-only;
  - is unchanged on simultaneous push and pop.
- wrrdy = (cnt != D). rdvld = (cnt != 0). wrnf = (cnt ≥ D-NFS).
- All three flags are derived combinationally from registered state, with no input-to-output combinational path.
- A write with wrvld=1 and wrrdy=0 is dropped. State is unchanged, and a message is printed when EDBG=1.
- When full, a same-cycle pop does not enable a push: wrrdy stays 0 for that cycle.
- When empty, a same-cycle push is not bypassed to the output: rdvld stays 0 for that cycle.
- Order is strictly preserved, including across pointer wrap-around.

## Timing
- Reset is asynchronous. Pointers and cnt clear immediately on rst.
  - Reset output values: rdvld=0, wrrdy=1, wrnf=(NFS ≥ D ? 1 : 0), which is 0 for legal NFS.
  - Stored contents are not cleared.
  - A reset mid-operation discards all entries.
- Write-to-read latency is 1 cycle: data pushed at edge N is visible with rdvld=1 after edge N.
- Flag updates:
  - wrrdy and wrnf update the cycle after the push that fills, or the pop that frees.
  - rdvld deasserts the cycle after the last pop.
- Throughput is one push and one pop per cycle when neither empty nor full.
- Upstream stages must hold wrvld/wraddr/wrdata until wrrdy=1.
  - Exception: a stage gated by wrnf may issue up to NFS beats after wrnf rises without loss.

## Structure
- Shared `powlib_std.vh` holds `powlib_clogb2` (the pointer and counter width function).
- Sub-module **powlib_dpram** is the storage array:
  - parameters W=B_AW+B_DW, D, EWBE=0;
  - registered write, asynchronous read;
  - ports wridx, wrdata, wrvld, rdidx, rddata, clk.
- Pointers and the counter are registers with async reset. powlib_flipflop (W, EAR=1; ports d, q, clk, rst) is the natural primitive.

## Test plan
- Reset, then idle: rdvld=0, wrrdy=1, wrnf=0. Push addr=0x10, data=0xA5 → next cycle rdvld=1, rdaddr=0x10, rddata=0xA5.
- D=8, NFS=3, rdrdy=0, push 8 beats:
  - wrnf rises after the 5th push;
  - wrrdy falls after the 8th push;
  - a 9th write (0xDEAD) is dropped.
  - Drain with rdrdy=1 → exactly the 8 beats, in order.
- Full FIFO, wrvld=1 and rdrdy=1 in the same cycle → one pop, no push, and cnt=7 afterwards.
- Empty FIFO, continuous push and pop every cycle of an incrementing 0..31 pattern → outputs 0..31 in order with 1-cycle lag; pointers wrap 4 times.
- Assert rst with 5 entries queued → rdvld=0 and wrrdy=1 immediately, without waiting for a clock edge. After release, a new push of 0x77 emerges first.
- Random wrvld/rdrdy for 10k cycles against a scoreboard queue → no loss, duplication or reordering; wrnf=(cnt ≥ D-NFS) every cycle.

Source files
------------

// File: rtl/powlib_bus_fifo_pkg.sv
// Shared helpers for the powlib bus FIFO slice.
// Holds the pointer/counter width function used by the FIFO and its storage.
package powlib_bus_fifo_pkg;

  function automatic int powlib_clogb2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/powlib_bus_fifo_dpram.sv
// Storage array for the bus FIFO.
// Registered write port, asynchronous read port.
module powlib_bus_fifo_dpram
  import powlib_bus_fifo_pkg::*;
#(
  parameter int W = 64,
  parameter int D = 8,
  localparam int AW = powlib_clogb2(D)
) (
  input  logic          clk,
  input  logic [AW-1:0] wridx,
  input  logic [W-1:0]  wrdata,
  input  logic          wrvld,
  input  logic [AW-1:0] rdidx,
  output logic [W-1:0]  rddata
);

  logic [W-1:0] mem_q [D];

  always_ff @(posedge clk) begin
    if (wrvld) mem_q[wridx] <= wrdata;
  end

  assign rddata = mem_q[rdidx];

endmodule

// File: rtl/powlib_bus_fifo.sv
// First-word-fall-through FIFO carrying {addr, data} with valid/ready
// on both sides and a programmable nearly-full flag.
module powlib_bus_fifo
  import powlib_bus_fifo_pkg::*;
#(
  parameter string ID   = "BUSFIFO",
  parameter int    EDBG = 0,
  parameter int    D    = 8,
  parameter int    NFS  = 0,
  parameter int    B_AW = 32,
  parameter int    B_DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [B_AW-1:0] wraddr,
  input  logic [B_DW-1:0] wrdata,
  input  logic            wrvld,
  output logic            wrrdy,
  output logic            wrnf,
  output logic [B_AW-1:0] rdaddr,
  output logic [B_DW-1:0] rddata,
  output logic            rdvld,
  input  logic            rdrdy
);

  localparam int W  = B_AW + B_DW;
  localparam int PW = powlib_clogb2(D);
  localparam int CW = powlib_clogb2(D + 1);

  logic [PW-1:0] wrptr_q, wrptr_d;
  logic [PW-1:0] rdptr_q, rdptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;
  logic [W-1:0]  rdent;

  // Flags come only from cnt_q, so no input reaches an output.
  assign wrrdy = (cnt_q != CW'(D));
  assign rdvld = (cnt_q != '0);
  assign wrnf  = (int'(cnt_q) >= D - NFS);

  assign push = wrvld && wrrdy;
  assign pop  = rdvld && rdrdy;

  always_comb begin
    wrptr_d = wrptr_q;
    rdptr_d = rdptr_q;
    cnt_d   = cnt_q;
    if (push) wrptr_d = wrptr_q + 1'b1;
    if (pop)  rdptr_d = rdptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      cnt_q   <= '0;
    end else begin
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      cnt_q   <= cnt_d;
    end
  end

  powlib_bus_fifo_dpram #(
    .W (W),
    .D (D)
  ) u_ram (
    .clk    (clk),
    .wridx  (wrptr_q),
    .wrdata ({wraddr, wrdata}),
    .wrvld  (push),
    .rdidx  (rdptr_q),
    .rddata (rdent)
  );

  assign rdaddr = rdent[W-1:B_DW];
  assign rddata = rdent[B_DW-1:0];

  if (EDBG != 0) begin : g_dbg
    // Debug trace of writes lost against a full FIFO.
    assert property (@(posedge clk) disable iff (rst) !(wrvld && !wrrdy))
      else $info("%s: dropped write addr=%h data=%h", ID, wraddr, wrdata);
  end

endmodule

// File: tb/tb_powlib_bus_fifo.sv
// Self-checking bench for powlib_bus_fifo against a queue model.
// Config: D=8, NFS=3, 16-bit address and data.
module tb_powlib_bus_fifo;

  localparam int D   = 8;
  localparam int NFS = 3;

  logic        clk;
  logic        rst;
  logic [15:0] wraddr;
  logic [15:0] wrdata;
  logic        wrvld;
  logic        wrrdy;
  logic        wrnf;
  logic [15:0] rdaddr;
  logic [15:0] rddata;
  logic        rdvld;
  logic        rdrdy;

  int errs;
  int checks;
  logic [31:0] mq[$];

  powlib_bus_fifo #(
    .D    (D),
    .NFS  (NFS),
    .B_AW (16),
    .B_DW (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wraddr (wraddr),
    .wrdata (wrdata),
    .wrvld  (wrvld),
    .wrrdy  (wrrdy),
    .wrnf   (wrnf),
    .rdaddr (rdaddr),
    .rddata (rddata),
    .rdvld  (rdvld),
    .rdrdy  (rdrdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle and advances the model; returns at the next negedge.
  task automatic drive(input logic v, input logic [15:0] a,
                       input logic [15:0] d, input logic r);
    int n;
    n = mq.size();
    wrvld  = v;
    wraddr = a;
    wrdata = d;
    rdrdy  = r;
    if (r && n != 0) void'(mq.pop_front());
    if (v && n != D) mq.push_back({a, d});
    @(posedge clk);
    @(negedge clk);
    wrvld = 1'b0;
    rdrdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wrvld = 1'b0;
    rdrdy = 1'b0;
    wraddr = '0;
    wrdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    @(negedge clk);
    checks++;
    if (rdvld !== 1'b0) begin
      errs++; $display("FAIL reset_rdvld got=%b exp=0", rdvld);
    end
    checks++;
    if (wrrdy !== 1'b1) begin
      errs++; $display("FAIL reset_wrrdy got=%b exp=1", wrrdy);
    end
    checks++;
    if (wrnf !== 1'b0) begin
      errs++; $display("FAIL reset_wrnf got=%b exp=0", wrnf);
    end
    drive(1'b1, 16'h0010, 16'h00A5, 1'b0);
    checks++;
    if (rdvld !== 1'b1) begin
      errs++; $display("FAIL first_rdvld got=%b exp=1", rdvld);
    end
    checks++;
    if (rdaddr !== 16'h0010 || rddata !== 16'h00A5) begin
      errs++;
      $display("FAIL first_word got=%h/%h exp=0010/00a5", rdaddr, rddata);
    end
    drive(1'b0, 16'h0, 16'h0, 1'b1);
    checks++;
    if (rdvld !== 1'b0) begin
      errs++; $display("FAIL first_drain got=%b exp=0", rdvld);
    end
  endtask

  task automatic test_fill_full();
    for (int i = 0; i < D; i++) begin
      drive(1'b1, 16'h0100 + 16'(i), 16'h5A00 + 16'(i), 1'b0);
      checks++;
      if (wrnf !== (i >= 4)) begin
        errs++; $display("FAIL fill_wrnf push=%0d got=%b exp=%b", i + 1, wrnf, i >= 4);
      end
      checks++;
      if (wrrdy !== (i < 7)) begin
        errs++; $display("FAIL fill_wrrdy push=%0d got=%b exp=%b", i + 1, wrrdy, i < 7);
      end
    end
    drive(1'b1, 16'hDEAD, 16'hDEAD, 1'b0);
    checks++;
    if (wrrdy !== 1'b0 || rdaddr !== 16'h0100) begin
      errs++; $display("FAIL drop_write wrrdy=%b head=%h exp 0/0100", wrrdy, rdaddr);
    end
    // Full with push and pop together: one pop, no push.
    drive(1'b1, 16'hBEEF, 16'hBEEF, 1'b1);
    checks++;
    if (wrrdy !== 1'b1 || wrnf !== 1'b1) begin
      errs++; $display("FAIL full_popwr wrrdy=%b wrnf=%b exp 1/1", wrrdy, wrnf);
    end
    for (int i = 1; i < D; i++) begin
      checks++;
      if (rdvld !== 1'b1 || rdaddr !== 16'h0100 + 16'(i) ||
          rddata !== 16'h5A00 + 16'(i)) begin
        errs++;
        $display("FAIL drain_beat %0d got=%b %h/%h exp=1 %h/%h", i, rdvld,
                 rdaddr, rddata, 16'h0100 + 16'(i), 16'h5A00 + 16'(i));
      end
      drive(1'b0, 16'h0, 16'h0, 1'b1);
    end
    checks++;
    if (rdvld !== 1'b0 || wrnf !== 1'b0) begin
      errs++; $display("FAIL drain_empty rdvld=%b wrnf=%b exp 0/0", rdvld, wrnf);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= 32; i++) begin
      if (i == 0) begin
        checks++;
        if (rdvld !== 1'b0) begin
          errs++; $display("FAIL b2b_start rdvld=%b exp=0", rdvld);
        end
      end else begin
        checks++;
        if (rdvld !== 1'b1 || rddata !== 16'(i - 1) || rdaddr !== 16'(i - 1)) begin
          errs++;
          $display("FAIL b2b_word %0d got=%b %h/%h exp=1 %h", i, rdvld,
                   rdaddr, rddata, 16'(i - 1));
        end
      end
      drive(i < 32, 16'(i), 16'(i), 1'b1);
    end
    checks++;
    if (rdvld !== 1'b0) begin
      errs++; $display("FAIL b2b_end rdvld=%b exp=0", rdvld);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 16'h0E00 + 16'(i), 16'(i), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rdvld !== 1'b0 || wrrdy !== 1'b1) begin
      errs++; $display("FAIL async_rst rdvld=%b wrrdy=%b exp 0/1", rdvld, wrrdy);
    end
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 16'h0077, 16'h0077, 1'b0);
    checks++;
    if (rdvld !== 1'b1 || rdaddr !== 16'h0077 || rddata !== 16'h0077) begin
      errs++;
      $display("FAIL post_rst got=%b %h/%h exp=1 0077/0077", rdvld, rdaddr, rddata);
    end
    drive(1'b0, 16'h0, 16'h0, 1'b1);
    checks++;
    if (rdvld !== 1'b0) begin
      errs++; $display("FAIL post_rst_empty rdvld=%b exp=0", rdvld);
    end
  endtask

  task automatic test_random();
    int n;
    int wp;
    int rp;
    logic [31:0] h;
    wp = 50;
    rp = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 1000 == 0) begin
        wp = $urandom_range(20, 90);
        rp = $urandom_range(20, 90);
      end
      n = mq.size();
      checks++;
      if (rdvld !== (n != 0) || wrrdy !== (n != D) || wrnf !== (n >= D - NFS)) begin
        errs++;
        $display("FAIL rand_flags cyc=%0d got=%b%b%b exp=%b%b%b n=%0d", c,
                 rdvld, wrrdy, wrnf, n != 0, n != D, n >= D - NFS, n);
      end
      if (n != 0) begin
        h = mq[0];
        checks++;
        if ({rdaddr, rddata} !== h) begin
          errs++;
          $display("FAIL rand_head cyc=%0d got=%h%h exp=%h", c, rdaddr, rddata, h);
        end
      end
      drive($urandom_range(0, 99) < wp, 16'($urandom), 16'($urandom),
            $urandom_range(0, 99) < rp);
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    test_reset();
    test_fill_full();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
